axis_uart_word_tx: RTL

Serializer between the matrix-vector multiplier's AXI-stream output and the board's UART TX pin. It accepts one wide result word per handshake and splits it into BITS_PER_WORD-bit characters, least-significant character first. Each character is sent as a framed asynchronous serial packet: start bit, data bits LSB-first, then stop bits. It is the downstream consumer of the sign-extended y bus in the UART-based MVM system.

---
 rtl/axis_uart_word_tx.sv | 118 +++++++++++
 1 files changed

// File: rtl/axis_uart_word_tx.sv
// axis_uart_word_tx: takes one W_OUT-bit word per valid/ready handshake and
// serializes it LSB-character-first as framed async serial packets on tx.
//
// Ports:
//   clk     - single clock
//   rstn    - asynchronous active-low reset
//   s_valid - upstream word valid
//   s_ready - high while idle and able to accept a word (registered)
//   s_data  - word to transmit; character i = s_data[BITS_PER_WORD*i +: BITS_PER_WORD]
//   tx      - serial line, idle high (registered)
module axis_uart_word_tx #(
    parameter int CLOCKS_PER_PULSE = 200_000_000 / 9600,
    parameter int BITS_PER_WORD    = 8,
    parameter int PACKET_SIZE      = BITS_PER_WORD + 5,
    parameter int W_OUT            = 256
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [W_OUT-1:0] s_data,
    output logic             tx
);

    localparam int NUM_WORDS = W_OUT / BITS_PER_WORD;
    localparam int PW = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
    localparam int BW = (PACKET_SIZE > 1) ? $clog2(PACKET_SIZE) : 1;
    localparam int WW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    localparam logic [PW-1:0] PULSE_LAST = PW'(CLOCKS_PER_PULSE - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(PACKET_SIZE - 1);
    localparam logic [WW-1:0] WORD_LAST  = WW'(NUM_WORDS - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t           state;
    logic [PW-1:0]    pulse_cnt;
    logic [BW-1:0]    bit_cnt;
    logic [WW-1:0]    word_cnt;
    logic [W_OUT-1:0] shreg;

    logic data_bit;
    logic line;
    logic pulse_end;
    logic bit_end;
    logic word_end;

    assign pulse_end = (pulse_cnt == PULSE_LAST);
    assign bit_end   = (bit_cnt == BIT_LAST);
    assign word_end  = (word_cnt == WORD_LAST);

    // Current character always sits in the low bits of shreg. Any bit_cnt
    // outside 1..BITS_PER_WORD falls through to 1, which covers stop bits.
    always_comb begin
        data_bit = 1'b1;
        for (int i = 0; i < BITS_PER_WORD; i++) begin
            if (bit_cnt == BW'(i + 1)) begin
                data_bit = shreg[i];
            end
        end
    end

    assign line = (bit_cnt == '0) ? 1'b0 : data_bit;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            pulse_cnt <= '0;
            bit_cnt   <= '0;
            word_cnt  <= '0;
            shreg     <= '0;
            tx        <= 1'b1;
            s_ready   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    tx      <= 1'b1;
                    s_ready <= 1'b1;
                    if (s_valid && s_ready) begin
                        shreg     <= s_data;
                        pulse_cnt <= '0;
                        bit_cnt   <= '0;
                        word_cnt  <= '0;
                        s_ready   <= 1'b0;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    // tx lags the counters by one cycle, so the first start
                    // bit appears one edge after the handshake.
                    tx <= line;
                    if (pulse_end) begin
                        pulse_cnt <= '0;
                        if (bit_end) begin
                            bit_cnt <= '0;
                            if (word_end) begin
                                word_cnt <= '0;
                                s_ready  <= 1'b1;
                                state    <= IDLE;
                            end else begin
                                word_cnt <= word_cnt + 1'b1;
                                shreg    <= shreg >> BITS_PER_WORD;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        pulse_cnt <= pulse_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
